// File: rtl/hb_decim_pkg.sv
// Shared constants for the halfband decimator: sample, pair-sum and accumulator
// widths, Q1.15 coefficients, FSM encodings and MAC schedule length.
package hb_decim_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned SUM_W      = SAMPLE_W + 1;
  localparam int unsigned PROD_W     = SUM_W + SAMPLE_W;
  localparam int unsigned ACC_W      = 36;
  localparam int unsigned TAPS       = 11;
  localparam int unsigned PAIRS      = 4;
  localparam int unsigned MAC_CYCLES = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [SUM_W-1:0]    sum_t;
  typedef logic signed [PROD_W-1:0]   prod_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  localparam sample_t COEF_H0 = 16'sd410;
  localparam sample_t COEF_H2 = -16'sd2464;
  localparam sample_t COEF_H4 = 16'sd10246;
  localparam sample_t COEF_H5 = 16'sd16384;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SNAP  = 3'd1;
  localparam state_t ST_MAC   = 3'd2;
  localparam state_t ST_ROUND = 3'd3;
  localparam state_t ST_OUT   = 3'd4;

  // Slot 0..2 are the symmetric pairs (h0, h2, h4), slot 3 is the centre tap.
  function automatic sample_t coef_sel(input logic [1:0] slot);
    sample_t c;
    case (slot)
      2'd0:    c = COEF_H0;
      2'd1:    c = COEF_H2;
      2'd2:    c = COEF_H4;
      default: c = COEF_H5;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hb_decim_mac_round_sat.sv
// Converts a Q1.15-scaled accumulator to a 16-bit sample: round half up,
// arithmetic shift by 15, then clamp to the signed 16-bit range.
module round_sat
  import hb_decim_pkg::*;
(
  input  logic signed [ACC_W-1:0]    acc_in,
  output logic signed [SAMPLE_W-1:0] sample_out
);

  localparam acc_t BIAS  = ACC_W'(16384);
  localparam acc_t MAX_S = ACC_W'(32767);
  localparam acc_t MIN_S = ACC_W'(-32768);

  acc_t shifted;

  always_comb begin
    shifted = (acc_in + BIAS) >>> 15;
    if (shifted > MAX_S) begin
      sample_out = 16'sh7FFF;
    end else if (shifted < MIN_S) begin
      sample_out = 16'sh8000;
    end else begin
      sample_out = shifted[SAMPLE_W-1:0];
    end
  end

endmodule

// File: rtl/hb_decim_mac.sv
// 11-tap halfband decimate-by-2 filter for I/Q, using a single shared 17x16
// multiplier time-multiplexed over both channels (8 MAC cycles per output).
module hb_decim_mac
  import hb_decim_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       strobe_in,
  input  logic signed [SAMPLE_W-1:0] data_in_i,
  input  logic signed [SAMPLE_W-1:0] data_in_q,
  output logic                       strobe_out,
  output logic signed [SAMPLE_W-1:0] data_out_i,
  output logic signed [SAMPLE_W-1:0] data_out_q,
  output logic                       overrun
);

  sample_t dl_i_q [TAPS];
  sample_t dl_i_d [TAPS];
  sample_t dl_q_q [TAPS];
  sample_t dl_q_d [TAPS];
  sum_t    snap_i_q [PAIRS];
  sum_t    snap_i_d [PAIRS];
  sum_t    snap_q_q [PAIRS];
  sum_t    snap_q_d [PAIRS];

  state_t  state_q, state_d;
  logic    phase_q, phase_d;
  logic [2:0] cnt_q, cnt_d;
  acc_t    acc_i_q, acc_i_d;
  acc_t    acc_q_q, acc_q_d;
  sample_t dout_i_q, dout_i_d;
  sample_t dout_q_q, dout_q_d;
  logic    stb_out_q, stb_out_d;
  logic    ovr_q, ovr_d;

  logic    accept;
  logic    trigger;
  sum_t    mult_a;
  sample_t mult_b;
  prod_t   prod;
  sample_t rnd_i, rnd_q;

  assign accept  = enable & strobe_in;
  assign trigger = accept & phase_q;

  // cnt[2] selects the channel, cnt[1:0] the pair slot / coefficient.
  always_comb begin
    mult_a = cnt_q[2] ? snap_q_q[cnt_q[1:0]] : snap_i_q[cnt_q[1:0]];
    mult_b = coef_sel(cnt_q[1:0]);
    prod   = PROD_W'(mult_a) * PROD_W'(mult_b);
  end

  round_sat u_round_i (
    .acc_in     (acc_i_q),
    .sample_out (rnd_i)
  );

  round_sat u_round_q (
    .acc_in     (acc_q_q),
    .sample_out (rnd_q)
  );

  always_comb begin
    dl_i_d   = dl_i_q;
    dl_q_d   = dl_q_q;
    snap_i_d = snap_i_q;
    snap_q_d = snap_q_q;
    phase_d  = phase_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_i_d  = acc_i_q;
    acc_q_d  = acc_q_q;
    dout_i_d = dout_i_q;
    dout_q_d = dout_q_q;
    ovr_d    = ovr_q;

    if (accept) begin
      for (int unsigned k = TAPS - 1; k > 0; k--) begin
        dl_i_d[k] = dl_i_q[k-1];
        dl_q_d[k] = dl_q_q[k-1];
      end
      dl_i_d[0] = data_in_i;
      dl_q_d[0] = data_in_q;
      phase_d   = ~phase_q;
    end

    if (!enable) begin
      phase_d = 1'b0;
      state_d = ST_IDLE;
    end else if (trigger) begin
      // A trigger always restarts from SNAP; outside IDLE the old result is dropped.
      state_d = ST_SNAP;
      if (state_q != ST_IDLE) ovr_d = 1'b1;
    end else begin
      case (state_q)
        ST_SNAP: begin
          snap_i_d[0] = sum_t'(dl_i_q[0]) + sum_t'(dl_i_q[10]);
          snap_i_d[1] = sum_t'(dl_i_q[2]) + sum_t'(dl_i_q[8]);
          snap_i_d[2] = sum_t'(dl_i_q[4]) + sum_t'(dl_i_q[6]);
          snap_i_d[3] = sum_t'(dl_i_q[5]);
          snap_q_d[0] = sum_t'(dl_q_q[0]) + sum_t'(dl_q_q[10]);
          snap_q_d[1] = sum_t'(dl_q_q[2]) + sum_t'(dl_q_q[8]);
          snap_q_d[2] = sum_t'(dl_q_q[4]) + sum_t'(dl_q_q[6]);
          snap_q_d[3] = sum_t'(dl_q_q[5]);
          acc_i_d     = '0;
          acc_q_d     = '0;
          cnt_d       = '0;
          state_d     = ST_MAC;
        end
        ST_MAC: begin
          if (cnt_q[2]) acc_q_d = acc_q_q + ACC_W'(prod);
          else          acc_i_d = acc_i_q + ACC_W'(prod);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'(MAC_CYCLES - 1)) state_d = ST_ROUND;
        end
        ST_ROUND: begin
          dout_i_d = rnd_i;
          dout_q_d = rnd_q;
          state_d  = ST_OUT;
        end
        ST_OUT:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    stb_out_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dl_i_q    <= '{default: '0};
      dl_q_q    <= '{default: '0};
      snap_i_q  <= '{default: '0};
      snap_q_q  <= '{default: '0};
      state_q   <= ST_IDLE;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
      dout_i_q  <= '0;
      dout_q_q  <= '0;
      stb_out_q <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      dl_i_q    <= dl_i_d;
      dl_q_q    <= dl_q_d;
      snap_i_q  <= snap_i_d;
      snap_q_q  <= snap_q_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      acc_i_q   <= acc_i_d;
      acc_q_q   <= acc_q_d;
      dout_i_q  <= dout_i_d;
      dout_q_q  <= dout_q_d;
      stb_out_q <= stb_out_d;
      ovr_q     <= ovr_d;
    end
  end

  assign strobe_out = stb_out_q;
  assign data_out_i = dout_i_q;
  assign data_out_q = dout_q_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_hb_decim_mac.sv
// Scoreboard bench for hb_decim_mac: a behavioural halfband model predicts each
// output and the cycle it must appear; a negedge monitor pops and compares.
module tb_hb_decim_mac;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic strobe_in = 1'b0;
  logic signed [15:0] data_in_i = '0;
  logic signed [15:0] data_in_q = '0;
  logic strobe_out;
  logic signed [15:0] data_out_i;
  logic signed [15:0] data_out_q;
  logic overrun;

  hb_decim_mac dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .strobe_in  (strobe_in),
    .data_in_i  (data_in_i),
    .data_in_q  (data_in_q),
    .strobe_out (strobe_out),
    .data_out_i (data_out_i),
    .data_out_q (data_out_q),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int due;
    int i;
    int q;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   seen_i[$];
  int   hi[11];
  int   hq[11];
  int   n_acc = 0;
  int   last_trig = -1000;
  bit   m_ov = 1'b0;
  int   m_last_i = 0;
  int   m_last_q = 0;
  bit   mon_en = 1'b0;
  exp_t mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int tap(input int k);
    if (k == 5) return 16384;
    if (k % 2 == 1) return 0;
    if (k == 4 || k == 6) return 10246;
    if (k == 2 || k == 8) return -2464;
    return 410;
  endfunction

  function automatic int filt(input int x[11]);
    longint acc = 0;
    for (int k = 0; k < 11; k++) acc += longint'(tap(k)) * longint'(x[k]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic void abort_from(input int eid);
    for (int k = sb.size() - 1; k >= 0; k--)
      if (sb[k].due >= eid) sb.delete(k);
  endfunction

  function automatic int rand_s16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic check_val(input string name, input logic signed [31:0] got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock of stimulus; the model is advanced for the edge that samples it.
  task automatic drive(input logic en, input logic rst, input logic stb, input int di, input int dq);
    int eid;
    @(posedge clock);
    #1;
    enable    = en;
    reset     = rst;
    strobe_in = stb;
    data_in_i = 16'(di);
    data_in_q = 16'(dq);
    eid = cyc + 1;
    if (rst) begin
      foreach (hi[k]) begin
        hi[k] = 0;
        hq[k] = 0;
      end
      n_acc = 0;
      m_ov = 1'b0;
      last_trig = -1000;
      m_last_i = 0;
      m_last_q = 0;
      abort_from(eid);
    end else if (!en) begin
      n_acc = 0;
      last_trig = -1000;
      abort_from(eid);
    end else if (stb) begin
      for (int k = 10; k > 0; k--) begin
        hi[k] = hi[k-1];
        hq[k] = hq[k-1];
      end
      hi[0] = di;
      hq[0] = dq;
      n_acc++;
      if (n_acc % 2 == 0) begin
        if (eid <= last_trig + 11) m_ov = 1'b1;
        abort_from(eid);
        last_trig = eid;
        sb.push_back('{due: eid + 10, i: filt(hi), q: filt(hq)});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic send(input int di, input int dq, input int gap);
    drive(1'b1, 1'b0, 1'b1, di, dq);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    idle(1);
  endtask

  task automatic compare_seen(input string name, input int ex[$]);
    check_val({name, "_count"}, seen_i.size(), ex.size());
    for (int k = 0; k < ex.size() && k < seen_i.size(); k++)
      check_val(name, seen_i[k], ex[k]);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_strobe_out due=%0d now=%0d", sb[0].due, cyc);
        void'(sb.pop_front());
      end
      if (strobe_out === 1'b1) begin
        checks++;
        if (sb.size() == 0 || sb[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_strobe_out cycle=%0d pending=%0d", cyc, sb.size());
        end else begin
          mon_e = sb.pop_front();
          if (data_out_i !== 16'(mon_e.i) || data_out_q !== 16'(mon_e.q)) begin
            errors++;
            $display("FAIL data_out cycle=%0d got=%0d/%0d expected=%0d/%0d",
                     cyc, data_out_i, data_out_q, mon_e.i, mon_e.q);
          end
          m_last_i = mon_e.i;
          m_last_q = mon_e.q;
          seen_i.push_back(int'(data_out_i));
        end
      end else if (strobe_out !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL strobe_out_unknown cycle=%0d got=%b", cyc, strobe_out);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int p_i[11];
    int p_q[11];
    int gap;

    do_reset();
    mon_en = 1'b1;
    @(negedge clock);
    check_val("reset_strobe_out", strobe_out, 0);
    check_val("reset_data_out_i", data_out_i, 0);
    check_val("reset_data_out_q", data_out_q, 0);
    check_val("reset_overrun", overrun, 0);

    // Impulse on the trigger-aligned sample: even taps appear in turn.
    seen_i.delete();
    send(0, 0, 6);
    send(16384, 0, 6);
    repeat (12) send(0, 0, 6);
    idle(20);
    compare_seen("impulse_even", '{205, -1232, 5123, 5123, -1232, 205, 0});

    // Impulse one sample earlier: only the centre tap contributes.
    do_reset();
    seen_i.delete();
    send(16384, 0, 6);
    repeat (13) send(0, 0, 6);
    idle(20);
    compare_seen("impulse_odd", '{0, 0, 8192, 0, 0, 0, 0});

    // DC gain of exactly one.
    do_reset();
    repeat (16) send(10000, -20000, 6);
    idle(20);
    @(negedge clock);
    check_val("dc_i", data_out_i, 10000);
    check_val("dc_q", data_out_q, -20000);
    repeat (12) send(32767, -32768, 6);
    idle(20);
    @(negedge clock);
    check_val("dc_full_i", data_out_i, 32767);
    check_val("dc_full_q", data_out_q, -32768);

    // Worst-case sign patterns must clamp, not wrap.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (tap(k) > 0) begin
        p_i[k] = 32767;
        p_q[k] = -32768;
      end else if (tap(k) < 0) begin
        p_i[k] = -32768;
        p_q[k] = 32767;
      end else begin
        p_i[k] = 0;
        p_q[k] = 0;
      end
    end
    send(0, 0, 6);
    for (int k = 10; k >= 0; k--) send(p_i[k], p_q[k], 6);
    idle(20);
    @(negedge clock);
    check_val("sat_pos_i", data_out_i, 32767);
    check_val("sat_neg_q", data_out_q, -32768);

    // Six-cycle spacing: every computation completes, no overrun.
    do_reset();
    repeat (20) send(rand_s16(), rand_s16(), 6);
    idle(20);
    @(negedge clock);
    check_val("spacing6_overrun", overrun, 0);

    // Four-cycle spacing: each trigger aborts the previous one.
    repeat (10) send(rand_s16(), rand_s16(), 4);
    idle(20);
    @(negedge clock);
    check_val("spacing4_overrun", overrun, 1);

    // Enable dropped mid-MAC: output held, no strobe, phase restarts.
    do_reset();
    repeat (4) send(rand_s16(), rand_s16(), 6);
    idle(15);
    send(rand_s16(), rand_s16(), 6);
    drive(1'b1, 1'b0, 1'b1, rand_s16(), rand_s16());
    idle(4);
    drive(1'b0, 1'b0, 1'b1, rand_s16(), rand_s16());
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    @(negedge clock);
    check_val("enable_hold_i", data_out_i, m_last_i);
    check_val("enable_hold_q", data_out_q, m_last_q);
    check_val("enable_low_strobe_out", strobe_out, 0);
    idle(15);
    repeat (8) send(rand_s16(), rand_s16(), 6);
    idle(20);

    // Reset mid-MAC after an overrun: everything clears the next cycle.
    repeat (3) send(rand_s16(), rand_s16(), 4);
    drive(1'b1, 1'b0, 1'b1, rand_s16(), rand_s16());
    idle(4);
    @(negedge clock);
    check_val("pre_reset_overrun", overrun, m_ov);
    drive(1'b1, 1'b1, 1'b0, 0, 0);
    idle(1);
    @(negedge clock);
    check_val("midreset_strobe_out", strobe_out, 0);
    check_val("midreset_data_out_i", data_out_i, 0);
    check_val("midreset_data_out_q", data_out_q, 0);
    check_val("midreset_overrun", overrun, 0);
    repeat (6) send(rand_s16(), rand_s16(), 6);
    idle(20);

    // Mixed random traffic with occasional enable drops and resets.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        repeat ($urandom_range(1, 3))
          drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), rand_s16(), rand_s16());
      end
      if ($urandom_range(0, 39) == 0) do_reset();
      gap = $urandom_range(4, 9);
      send(rand_s16(), rand_s16(), gap);
    end
    idle(30);
    @(negedge clock);
    check_val("final_overrun", overrun, m_ov);
    check_val("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hb_decim_mac.md
HB_DECIM_MAC -- requirements
Module: hb_decim_mac

Interface
REQ-001 The block SHALL have no parameters; sample width is fixed at 16 bits signed, two's complement.
REQ-002 clock  input  1  single clock; all logic is on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  high = run; low = synchronous soft clear per REQ-019.
REQ-005 strobe_in  input  1  one-cycle pulse qualifying data_in_i/data_in_q.
REQ-006 data_in_i, data_in_q  input  16 each  input I/Q samples, valid when strobe_in=1.
REQ-007 strobe_out  output  1  one-cycle pulse marking a new decimated output.
REQ-008 data_out_i, data_out_q  output  16 each  filtered, decimated-by-2 I/Q samples.
REQ-009 overrun  output  1  sticky flag; cleared only by reset.

Function
REQ-010 Each channel SHALL hold an 11-entry delay line x[0..10], with x[0] the newest sample.
- Shifts on every strobe_in with enable=1.
REQ-011 Halfband coefficients (Q1.15) SHALL be h0=h10=410, h2=h8=-2464, h4=h6=10246, h5=16384, all odd-index taps 0.
- DC gain is exactly 1.0.
REQ-012 A phase bit SHALL toggle on each accepted strobe_in; when phase=1 before the toggle, that strobe is a trigger.
- The first trigger is the 2nd accepted sample after reset.
REQ-013 FSM states SHALL be IDLE, SNAP, MAC, ROUND, OUT.
- Trigger in IDLE -> SNAP.
- SNAP -> MAC.
- MAC runs 8 cycles, counter 0..7 -> ROUND.
- ROUND -> OUT.
- OUT -> IDLE.
REQ-014 In SNAP, the block SHALL capture per channel the 17-bit pair sums x0+x10, x2+x8, x4+x6 and sign-extended x5 from the just-shifted delay line.
- The delay line is then free to keep shifting.
REQ-015 MAC SHALL use one shared 17x16 signed multiplier and one 36-bit signed accumulator per channel.
- Order: I pairs 0,2,4, I centre, then Q pairs 0,2,4, Q centre.
REQ-016 ROUND SHALL compute (acc + 2^14) >>> 15 and saturate to [-32768, 32767], then register data_out_i/q.
REQ-017 strobe_out SHALL be high for exactly the OUT cycle, 11 cycles after the triggering strobe_in cycle.
- data_out holds its value until the next OUT.
REQ-018 A trigger while state != IDLE SHALL do all of the following:
- set overrun;
- abort the current computation (no strobe_out for it);
- restart at SNAP.
- Minimum overrun-free strobe_in spacing is 6 cycles.
REQ-019 enable=0 SHALL do all of the following:
- force state to IDLE and phase to 0;
- force strobe_out to 0;
- ignore strobe_in;
- hold the delay line, data_out and overrun.
REQ-020 strobe_in coinciding with OUT SHALL be accepted normally (shift and phase update); only a trigger in OUT counts as overrun.

Reset
REQ-021 reset=1 SHALL synchronously zero all of the following: delay lines, snapshots, accumulators, phase, counter, data_out_i/q, strobe_out and overrun, with state=IDLE.
REQ-022 Reset SHALL take priority over enable and strobe_in, including mid-computation; no strobe_out follows an aborted computation.

Structure
REQ-023 Coefficient constants, the 36-bit accumulator width, the FSM state encodings and MAC cycle count SHALL live in a shared package/include, hb_decim_pkg.
REQ-024 One sub-module, round_sat (36-bit in, 16-bit rounded and saturated out), SHALL be used; all else is flat.

Verification
REQ-025 Impulse test:
- Stimulus: I=16384 on one odd sample, zeros elsewhere.
- Response: successive data_out_i 205, -1232, 5123, 5123, -1232, 205.
- Stimulus shifted by one sample: a single 8192.
- data_out_q stays 0.
REQ-026 DC test:
- Stimulus: constant 10000 on I and -20000 on Q.
- Response: after 6 outputs, outputs are exactly 10000 / -20000.
- Stimulus: constant 32767 / -32768.
- Response: output 32767 / -32768.
REQ-027 Saturation test:
- Stimulus: x = +32767 where the coefficient is positive and -32768 where it is negative.
- Response: data_out = 32767, with no wrap.
- Stimulus: the sign-inverted pattern.
- Response: data_out = -32768.
REQ-028 Timing and overrun test:
- strobe_in every 6 cycles -> strobe_out exactly 11 cycles after each trigger, overrun=0.
- strobe_in every 4 cycles -> overrun=1, and strobe_out only for the final, unaborted computation.
REQ-029 Control test:
- Stimulus: enable dropped during MAC.
- Response: no strobe_out; data_out unchanged; resumes correctly when enable is raised.
- Stimulus: reset pulsed during MAC.
- Response: all outputs 0 the next cycle; first trigger is the 2nd post-reset sample.
